// File: rtl/queuenm_pkg.sv
// Shared helpers for the circular M/N queue: width derivations and age-to-slot mapping.
package queuenm_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned q_length);
    return clog2(q_length);
  endfunction

  // One extra bit so a full queue (count == Q_LENGTH) is representable.
  function automatic int unsigned cnt_w(input int unsigned q_length);
    return clog2(q_length) + 1;
  endfunction

  function automatic int unsigned age_to_phys(input int unsigned rd_ptr, input int unsigned age,
                                              input int unsigned q_length);
    return (rd_ptr + age) % q_length;
  endfunction

endpackage

// File: rtl/queuenm_circ_if.sv
// Producer/consumer bundle for queuenm_circ; master drives push/pop/modify, slave is the queue.
interface queuenm_circ_if
  import queuenm_pkg::*;
#(
  parameter int unsigned M_WIDTH  = 16,
  parameter int unsigned N_WIDTH  = 16,
  parameter int unsigned Q_LENGTH = 16
);
  localparam int unsigned CNT_W = cnt_w(Q_LENGTH);

  logic [M_WIDTH-1:0]          m_din;
  logic [N_WIDTH-1:0]          n_din;
  logic                        wr;
  logic                        rd;
  logic [Q_LENGTH-1:0]         modify_vector;
  logic [M_WIDTH*Q_LENGTH-1:0] new_m_vector;
  logic [M_WIDTH*Q_LENGTH-1:0] old_m_vector;
  logic [Q_LENGTH-1:0]         valid_vector;
  logic [M_WIDTH+N_WIDTH-1:0]  dout;
  logic [CNT_W-1:0]            count;
  logic                        full;
  logic                        empty;
  logic                        almost_full;
  logic                        err;

  modport master (
    output m_din, n_din, wr, rd, modify_vector, new_m_vector,
    input  old_m_vector, valid_vector, dout, count, full, empty, almost_full, err
  );

  modport slave (
    input  m_din, n_din, wr, rd, modify_vector, new_m_vector,
    output old_m_vector, valid_vector, dout, count, full, empty, almost_full, err
  );

endinterface

// File: rtl/queue_ptr_ctr.sv
// Wrapping queue pointer with increment enable and synchronous clear.
module queue_ptr_ctr #(
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;

  // Depth is a power of two, so natural overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/queuenm_circ.sv
// Circular M/N queue with in-place M rewrite by age, simultaneous push/pop and occupancy flags.
// Optional sticky overflow/underflow flag built only when QUEUENM_ERR_EN is defined.
module queuenm_circ
  import queuenm_pkg::*;
#(
  parameter int unsigned M_WIDTH   = 16,
  parameter int unsigned N_WIDTH   = 16,
  parameter int unsigned Q_LENGTH  = 16,
  parameter int unsigned AF_THRESH = 12
) (
  input logic            clk,
  input logic            clr,
  queuenm_circ_if.slave  q
);

  localparam int unsigned PTR_W = ptr_w(Q_LENGTH);
  localparam int unsigned CNT_W = cnt_w(Q_LENGTH);

  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [M_WIDTH-1:0] m_mem [Q_LENGTH];
  logic [N_WIDTH-1:0] n_mem [Q_LENGTH];
  logic [PTR_W-1:0]   phys  [Q_LENGTH];
  logic [Q_LENGTH-1:0] valid;
  logic empty, full, pop_acc, push_acc;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(Q_LENGTH));
    pop_acc  = q.rd && !empty;
    push_acc = q.wr && (!full || pop_acc);
  end

  always_comb begin
    for (int unsigned i = 0; i < Q_LENGTH; i++) begin
      phys[i]  = PTR_W'(age_to_phys(32'(rd_ptr), i, Q_LENGTH));
      valid[i] = (CNT_W'(i) < count_q);
    end
  end

  queue_ptr_ctr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .clr (clr),
    .inc (pop_acc),
    .ptr (rd_ptr)
  );

  queue_ptr_ctr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .clr (clr),
    .inc (push_acc),
    .ptr (wr_ptr)
  );

  always_comb begin
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A departing head is not rewritten; the push slot is never valid, so the push write wins.
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int unsigned i = 0; i < Q_LENGTH; i++) begin
        if (q.modify_vector[i] && valid[i] && !(i == 0 && pop_acc)) begin
          m_mem[phys[i]] <= q.new_m_vector[i*M_WIDTH +: M_WIDTH];
        end
      end
      if (push_acc) begin
        m_mem[wr_ptr] <= q.m_din;
        n_mem[wr_ptr] <= q.n_din;
      end
    end
  end

  always_comb begin
    q.old_m_vector = '0;
    for (int unsigned i = 0; i < Q_LENGTH; i++) begin
      q.old_m_vector[i*M_WIDTH +: M_WIDTH] = valid[i] ? m_mem[phys[i]] : '0;
    end
    q.dout         = empty ? '0 : {m_mem[rd_ptr], n_mem[rd_ptr]};
    q.valid_vector = valid;
    q.count        = count_q;
    q.full         = full;
    q.empty        = empty;
    q.almost_full  = (count_q >= CNT_W'(AF_THRESH));
  end

`ifdef QUEUENM_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      err_q <= 1'b0;
    end else if ((q.wr && full && !q.rd) || (q.rd && empty && !q.wr)) begin
      err_q <= 1'b1;
    end
  end

  assign q.err = err_q;
`else
  assign q.err = 1'b0;
`endif

endmodule

// File: tb/tb_queuenm_circ.sv
// Scoreboard bench for queuenm_circ: a queue-of-entries reference model predicts every cycle.
module tb_queuenm_circ;

  localparam int Q  = 16;
  localparam int AF = 12;

  typedef struct {
    logic [15:0] m;
    logic [15:0] n;
  } ent_t;

  typedef struct packed {
    logic [4:0]   count;
    logic         empty;
    logic         full;
    logic         af;
    logic         err;
    logic [31:0]  dout;
    logic [15:0]  valid;
    logic [255:0] oldm;
  } snap_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  queuenm_circ_if #(.M_WIDTH(16), .N_WIDTH(16), .Q_LENGTH(Q)) bus ();

  queuenm_circ #(.M_WIDTH(16), .N_WIDTH(16), .Q_LENGTH(Q), .AF_THRESH(AF)) dut (
    .clk (clk),
    .clr (clr),
    .q   (bus)
  );

  ent_t  model[$];
  bit    merr;
  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic snap_t expect_snap();
    snap_t s;
    int sz;
    sz      = model.size();
    s.count = 5'(sz);
    s.empty = (sz == 0);
    s.full  = (sz == Q);
    s.af    = (sz >= AF);
    s.err   = merr;
    s.dout  = (sz > 0) ? {model[0].m, model[0].n} : 32'h0;
    s.valid = '0;
    s.oldm  = '0;
    for (int i = 0; i < sz; i++) begin
      s.valid[i]          = 1'b1;
      s.oldm[i*16 +: 16]  = model[i].m;
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // One clock of stimulus; new_m slices are model M << 2 for live entries, random elsewhere.
  task automatic drive(input bit c, input bit w, input bit r, input logic [15:0] m,
                       input logic [15:0] n, input logic [15:0] mod);
    logic [255:0] nm;
    ent_t e;
    bit pop, push;
    int sz;
    sz = model.size();
    for (int i = 0; i < Q; i++) begin
      nm[i*16 +: 16] = (i < sz) ? (model[i].m << 2) : 16'($urandom);
    end
    clr               = c;
    bus.wr            = w;
    bus.rd            = r;
    bus.m_din         = m;
    bus.n_din         = n;
    bus.modify_vector = mod;
    bus.new_m_vector  = nm;
    @(posedge clk);
    if (c) begin
      model.delete();
      merr = 1'b0;
    end else begin
`ifdef QUEUENM_ERR_EN
      if ((w && sz == Q && !r) || (r && sz == 0 && !w)) merr = 1'b1;
`endif
      pop  = r && (sz > 0);
      push = w && ((sz < Q) || pop);
      for (int i = 0; i < sz; i++) begin
        if (mod[i] && !(i == 0 && pop)) begin
          e       = model[i];
          e.m     = nm[i*16 +: 16];
          model[i] = e;
        end
      end
      if (pop) void'(model.pop_front());
      if (push) begin
        e.m = m;
        e.n = n;
        model.push_back(e);
      end
    end
    exp_q.push_back(expect_snap());
    #1;
  endtask

  always @(negedge clk) begin
    snap_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check("count", 256'(bus.count), 256'(s.count));
      check("flags{empty,full,af}", 256'({bus.empty, bus.full, bus.almost_full}),
            256'({s.empty, s.full, s.af}));
      check("err", 256'(bus.err), 256'(s.err));
      check("dout", 256'(bus.dout), 256'(s.dout));
      check("valid_vector", 256'(bus.valid_vector), 256'(s.valid));
      check("old_m_vector", bus.old_m_vector, s.oldm);
    end
  end

  initial begin
    merr = 1'b0;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.m_din = '0;
    bus.n_din = '0;
    bus.modify_vector = '0;
    bus.new_m_vector = '0;

    // Reset
    drive(1, 0, 0, 16'h0, 16'h0, 16'h0);
    drive(0, 0, 0, 16'h0, 16'h0, 16'h0);

    // Fill to full, then an overflow attempt
    for (int k = 0; k < 16; k++) drive(0, 1, 0, 16'hFFFF, {4{4'(k)}}, 16'h0);
    drive(0, 1, 0, 16'h1234, 16'h5678, 16'h0);

    // Sustained push/pop while full
    for (int k = 0; k < 4; k++) drive(0, 1, 1, 16'($urandom), 16'hAAAA, 16'h0);

    // Modify-all while draining 9 entries, with extra underflow pops
    drive(1, 0, 0, 16'h0, 16'h0, 16'h0);
    for (int k = 0; k < 9; k++) drive(0, 1, 0, 16'hFFFF, {4{4'(k)}}, 16'h0);
    for (int k = 0; k < 12; k++) drive(0, 0, 1, 16'h0, 16'h0, 16'hFFFF);

    // Pointer wrap
    drive(1, 0, 0, 16'h0, 16'h0, 16'h0);
    for (int k = 0; k < 9; k++) drive(0, 1, 0, 16'(k * 3 + 1), {4{4'(k)}}, 16'h0);
    for (int k = 0; k < 9; k++) drive(0, 0, 1, 16'h0, 16'h0, 16'h0);
    for (int k = 9; k < 16; k++) drive(0, 1, 0, 16'(k * 3 + 1), {4{4'(k)}}, 16'h0);
    drive(0, 0, 0, 16'h0, 16'h0, 16'h0);

    // Reset colliding with a write
    drive(1, 0, 0, 16'h0, 16'h0, 16'h0);
    for (int k = 0; k < 5; k++) drive(0, 1, 0, 16'(k), 16'(k + 100), 16'h0);
    drive(1, 1, 0, 16'hDEAD, 16'hBEEF, 16'hFFFF);
    drive(0, 1, 0, 16'h5A5A, 16'hA5A5, 16'h0);
    drive(0, 0, 0, 16'h0, 16'h0, 16'h0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5),
            16'($urandom), 16'($urandom), 16'($urandom));
    end
    drive(0, 0, 0, 16'h0, 16'h0, 16'h0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
